// File: rtl/seg_scan_driver_if.sv
// Segment-pattern write channel: the encoder side (master) pushes one
// 8-bit active-low pattern per digit index; the scan driver (slave) accepts
// it and flags out-of-range indices.
interface seg_scan_driver_if #(
  parameter int unsigned IDX_W = 2
);
  logic             wr_valid;
  logic             wr_ready;
  logic [IDX_W-1:0] wr_index;
  logic [7:0]       wr_seg;
  logic             wr_err;

  modport master (
    output wr_valid, wr_index, wr_seg,
    input  wr_ready, wr_err
  );

  modport slave (
    input  wr_valid, wr_index, wr_seg,
    output wr_ready, wr_err
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Common-anode display scanner: double-buffered per-digit patterns, one
// anode per slot with a dark guard interval at the start of every slot.
// Shadow buffer is copied to the active buffer on the last cycle of a frame.
module seg_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned IDX_W        = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  seg_scan_driver_if.slave      wr,
  input  logic                  blank_all,
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] anode_out,
  output logic [IDX_W-1:0]      scan_index,
  output logic                  frame_tick
);

  localparam int unsigned      CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W:0]   BLANK_END = (CNT_W + 1)'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] DIG_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W:0]   DIG_COUNT = (IDX_W + 1)'(NUM_DIGITS);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [CNT_W-1:0]      slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
  logic [7:0]            shadow_q [NUM_DIGITS];
  logic [7:0]            shadow_d [NUM_DIGITS];
  logic [7:0]            active_q [NUM_DIGITS];
  logic [7:0]            active_d [NUM_DIGITS];
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  tick_q, tick_d;
  logic                  err_q, err_d;

  logic       slot_wrap;
  logic       copy_cycle;
  logic       wr_fire;
  logic       idx_ok;
  logic [0:0] scan_state;

  // Slot/digit counters and frame-boundary detection
  always_comb begin
    slot_wrap  = (slot_cnt_q == SLOT_LAST);
    copy_cycle = slot_wrap && (scan_idx_q == DIG_LAST);
    scan_state = ({1'b0, slot_cnt_q} < BLANK_END) ? ST_BLANK : ST_DRIVE;
    slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (slot_wrap) begin
      scan_idx_d = (scan_idx_q == DIG_LAST) ? '0 : scan_idx_q + 1'b1;
    end
  end

  // Write handshake into the shadow buffer; ready drops on the copy cycle so
  // a write can never race the shadow-to-active transfer
  always_comb begin
    wr.wr_ready = !reset && !copy_cycle;
    wr_fire     = wr.wr_valid && wr.wr_ready;
    idx_ok      = ({1'b0, wr.wr_index} < DIG_COUNT);
    shadow_d    = shadow_q;
    if (wr_fire && idx_ok) begin
      shadow_d[wr.wr_index] = wr.wr_seg;
    end
    err_d       = wr_fire && !idx_ok;
    active_d    = copy_cycle ? shadow_q : active_q;
  end

  // Output pattern for the current slot, registered one cycle behind state
  always_comb begin
    seg_d   = 8'hFF;
    anode_d = '1;
    tick_d  = copy_cycle;
    if (!blank_all && (scan_state == ST_DRIVE)) begin
      anode_d[scan_idx_q] = 1'b0;
      seg_d               = active_q[scan_idx_q];
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt_q <= '0;
      scan_idx_q <= '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= 8'hFF;
        active_q[i] <= 8'hFF;
      end
      seg_q   <= 8'hFF;
      anode_q <= '1;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      scan_idx_q <= scan_idx_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      seg_q      <= seg_d;
      anode_q    <= anode_d;
      tick_q     <= tick_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    seg_out    = seg_q;
    anode_out  = anode_q;
    scan_index = scan_idx_q;
    frame_tick = tick_q;
    wr.wr_err  = err_q;
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (4 digits, 8-cycle slots, 2 blank
// cycles). Stimulus queues hand-computed expectations tagged with
// (reset epoch, cycle); a negedge monitor pops and compares them.
module tb_seg_scan_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       blank_all = 1'b0;
  logic [7:0] seg_out;
  logic [3:0] anode_out;
  logic [1:0] scan_index;
  logic       frame_tick;

  logic [7:0] seg3;
  logic [2:0] anode3;
  logic [1:0] scan3;
  logic       tick3;

  seg_scan_driver_if #(.IDX_W(2)) wr_if ();
  seg_scan_driver_if #(.IDX_W(2)) w3_if ();

  seg_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .IDX_W(2)
  ) u_dut (
    .clk(clk), .reset(reset), .wr(wr_if), .blank_all(blank_all),
    .seg_out(seg_out), .anode_out(anode_out), .scan_index(scan_index),
    .frame_tick(frame_tick)
  );

  // Three-digit instance so an out-of-range index is representable
  seg_scan_driver #(
    .NUM_DIGITS(3), .REFRESH_DIV(8), .BLANK_CYCLES(2), .IDX_W(2)
  ) u_dut3 (
    .clk(clk), .reset(reset), .wr(w3_if), .blank_all(1'b0),
    .seg_out(seg3), .anode_out(anode3), .scan_index(scan3),
    .frame_tick(tick3)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] M_SEG = 5'b00001;
  localparam logic [4:0] M_AN  = 5'b00010;
  localparam logic [4:0] M_TK  = 5'b00100;
  localparam logic [4:0] M_SC  = 5'b01000;
  localparam logic [4:0] M_RDY = 5'b10000;
  localparam logic [4:0] M_SA  = M_SEG | M_AN;
  localparam logic [4:0] M_ALL = 5'b11111;

  typedef struct {
    int         ep;
    int         cyc;
    logic [7:0] seg;
    logic [3:0] an;
    logic       tick;
    logic [1:0] scan;
    logic       rdy;
    logic [4:0] m;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ep = 0;
  logic in_rst = 1'b0;
  int   stim_ep = 0;

  // Cycle numbering: cycle 1 is the first edge after reset drops
  always @(posedge clk) begin
    if (reset) begin
      cyc <= 0;
      if (!in_rst) ep <= ep + 1;
      in_rst <= 1'b1;
    end else begin
      cyc    <= cyc + 1;
      in_rst <= 1'b0;
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s ep%0d cyc%0d got %0h expected %0h", nm, ep, cyc, act, expv);
    end
  endtask

  task automatic push(input int e, input int c, input logic [7:0] s, input logic [3:0] a,
                      input logic t, input logic [1:0] sc, input logic r, input logic [4:0] m);
    exp_t x;
    x.ep = e; x.cyc = c; x.seg = s; x.an = a; x.tick = t; x.scan = sc; x.rdy = r; x.m = m;
    sbq.push_back(x);
  endtask

  // Monitor: compare every expectation due at this cycle
  always @(negedge clk) begin : mon
    exp_t e;
    bit   go;
    go = 1'b1;
    while (go && sbq.size() > 0) begin
      e = sbq[0];
      if (e.ep == ep && e.cyc == cyc) begin
        void'(sbq.pop_front());
        if (e.m[0]) chk("seg_out", int'(seg_out), int'(e.seg));
        if (e.m[1]) chk("anode_out", int'(anode_out), int'(e.an));
        if (e.m[2]) chk("frame_tick", int'(frame_tick), int'(e.tick));
        if (e.m[3]) chk("scan_index", int'(scan_index), int'(e.scan));
        if (e.m[4]) chk("wr_ready", int'(wr_if.wr_ready), int'(e.rdy));
      end else if (e.ep < ep || (e.ep == ep && e.cyc < cyc)) begin
        void'(sbq.pop_front());
        chk("missed_expectation", cyc, e.cyc);
      end else begin
        go = 1'b0;
      end
    end
  end

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (!(ep == stim_ep && cyc == n)) begin
      @(negedge clk);
      guard++;
      if (guard > 300) begin
        chk("wait_timeout", cyc, n);
        return;
      end
    end
  endtask

  task automatic do_write(input logic [1:0] idx, input logic [7:0] s);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_index = idx;
    wr_if.wr_seg   = s;
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog reached at cyc%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit took;
    wr_if.wr_valid = 1'b0; wr_if.wr_index = '0; wr_if.wr_seg = '0;
    w3_if.wr_valid = 1'b0; w3_if.wr_index = '0; w3_if.wr_seg = '0;

    // Epoch 1: power-on reset, two frames of writes/blanking/copy checks
    push(1, 1, 8'hFF, 4'hF, 0, 0, 1, M_ALL);
    push(1, 2, 8'hFF, 4'hF, 0, 0, 1, M_SA | M_TK);
    push(1, 3, 8'hFF, 4'hE, 0, 0, 1, M_SA);
    push(1, 7, 8'hFF, 4'hE, 0, 0, 1, M_SC);
    push(1, 8, 8'hFF, 4'hE, 0, 0, 1, M_SA);
    push(1, 9, 8'hFF, 4'hF, 0, 1, 1, M_SA | M_SC);
    push(1, 11, 8'hFF, 4'hD, 0, 1, 1, M_SA);
    push(1, 16, 8'hFF, 4'hD, 0, 1, 1, M_SA);
    push(1, 31, 8'hFF, 4'h7, 0, 3, 0, M_SA | M_TK | M_SC | M_RDY);
    push(1, 32, 8'hFF, 4'h7, 1, 0, 1, M_ALL);
    push(1, 33, 8'hFF, 4'hF, 0, 0, 1, M_SA | M_TK);
    push(1, 35, 8'hC0, 4'hE, 0, 0, 1, M_SA);
    push(1, 36, 8'hFF, 4'hF, 0, 0, 1, M_SA);
    push(1, 40, 8'hFF, 4'hF, 0, 0, 1, M_SA);
    push(1, 41, 8'hFF, 4'hF, 0, 1, 1, M_SA | M_SC);
    push(1, 43, 8'hF2, 4'hD, 0, 1, 1, M_SA);
    push(1, 51, 8'hFF, 4'hB, 0, 2, 1, M_SA);
    push(1, 59, 8'hF9, 4'h7, 0, 3, 1, M_SA);
    push(1, 64, 8'hF9, 4'h7, 1, 0, 1, M_SA | M_TK | M_SC);
    push(1, 67, 8'hC0, 4'hE, 0, 0, 1, M_SA);
    push(1, 75, 8'h99, 4'hD, 0, 1, 1, M_SA);
    push(1, 83, 8'hA4, 4'hB, 0, 2, 1, M_SA);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    stim_ep = 1;

    wait_cyc(1);
    do_write(2'd0, 8'hC0);
    do_write(2'd3, 8'hF9);
    do_write(2'd1, 8'h12);
    do_write(2'd1, 8'hF2);

    // Out-of-range index on the three-digit instance
    chk("err3_idle", int'(w3_if.wr_err), 0);
    w3_if.wr_valid = 1'b1; w3_if.wr_index = 2'd3; w3_if.wr_seg = 8'h00;
    @(negedge clk);
    chk("err3_pulse", int'(w3_if.wr_err), 1);
    w3_if.wr_index = 2'd2;
    @(negedge clk);
    chk("err3_inrange", int'(w3_if.wr_err), 0);
    w3_if.wr_valid = 1'b0;
    @(negedge clk);
    chk("err3_after", int'(w3_if.wr_err), 0);

    // Write held across the copy cycle
    wait_cyc(31);
    wr_if.wr_valid = 1'b1; wr_if.wr_index = 2'd1; wr_if.wr_seg = 8'h99;
    took = 1'b0;
    for (int k = 0; k < 8 && !took; k++) begin
      if (wr_if.wr_ready) took = 1'b1;
      @(negedge clk);
    end
    wr_if.wr_valid = 1'b0;
    chk("copy_write_taken", int'(took), 1);
    chk("copy_write_cycle", cyc, 33);

    wait_cyc(35);
    blank_all = 1'b1;
    wait_cyc(41);
    blank_all = 1'b0;

    wait_cyc(50);
    do_write(2'd2, 8'hA4);

    // Epoch 2: reset mid-frame, then a write that must not survive reset
    wait_cyc(90);
    push(2, 0, 8'hFF, 4'hF, 0, 0, 0, M_SA | M_TK | M_SC);
    push(2, 3, 8'hFF, 4'hE, 0, 0, 1, M_SA);
    push(2, 16, 8'hFF, 4'hD, 0, 1, 1, M_SA);
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    stim_ep = 2;
    wait_cyc(2);
    do_write(2'd0, 8'h55);

    // Epoch 3: one-cycle reset at cycle 20; buffers must read back blank
    wait_cyc(20);
    push(3, 0, 8'hFF, 4'hF, 0, 0, 0, M_SA | M_TK | M_SC);
    push(3, 1, 8'hFF, 4'hF, 0, 0, 1, M_ALL);
    push(3, 3, 8'hFF, 4'hE, 0, 0, 1, M_SA);
    push(3, 11, 8'hFF, 4'hD, 0, 1, 1, M_SA);
    push(3, 31, 8'hFF, 4'h7, 0, 3, 0, M_RDY | M_TK);
    push(3, 32, 8'hFF, 4'h7, 1, 0, 1, M_TK);
    push(3, 35, 8'hFF, 4'hE, 0, 0, 1, M_SA);
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    stim_ep = 3;

    wait_cyc(40);
    @(negedge clk);
    chk("queue_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Receiving end of the segment-pattern interface: accepts 8-bit active-low segment patterns (bit7 = dp, bits6..0 = g..a), one per digit position.
- Buffers patterns per digit, double-buffered so the display never tears.
- Time-multiplexes the common-anode display, driving one anode at a time with a ghosting guard interval.
- Sits between the tuner's digit/pattern encoders and the board's shared seg/anode pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (2..8).
- REFRESH_DIV, 100000, clk cycles per digit slot; must be > BLANK_CYCLES.
- BLANK_CYCLES, 4, cycles at the start of each slot with all anodes off (0 allowed).
- IDX_W, 2, width of the index ports (= clog2(NUM_DIGITS), minimum 1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_valid  in  1  write request
- wr_ready  out  1  write can be accepted this cycle
- wr_index  in  IDX_W  target digit position
- wr_seg  in  8  active-low segment pattern
- wr_err  out  1  one-cycle pulse: accepted write had wr_index >= NUM_DIGITS
- blank_all  in  1  force display dark
- seg_out  out  8  active-low segment pins
- anode_out  out  NUM_DIGITS  active-low anode enables
- scan_index  out  IDX_W  digit currently in its slot
- frame_tick  out  1  one-cycle pulse at frame boundary

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - Reset clears: shadow[] = 8'hFF, active[] = 8'hFF, slot_cnt = 0, scan_index = 0.
  - Reset drives: seg_out = 8'hFF, anode_out = all 1, frame_tick = 0, wr_err = 0, wr_ready = 0.
  - Reset mid-operation drops any in-flight write and restarts the scan at digit 0.
- Write handshake:
  - A write transfers when wr_valid && wr_ready at a rising edge; the pattern goes to shadow[wr_index].
  - wr_ready = !reset && !copy_cycle, where copy_cycle = (slot_cnt == REFRESH_DIV-1) && (scan_index == NUM_DIGITS-1).
  - wr_valid held while wr_ready = 0 is accepted on the next ready cycle.
  - An out-of-range index is accepted and discarded; wr_err pulses high the following cycle.
  - Back-to-back writes are allowed every ready cycle. Last write to the same index wins.
- Double buffer:
  - On copy_cycle, active[] <= shadow[] (all digits at once).
  - Shadow writes become visible only from the next frame's digit-0 slot.
- Scan FSM:
  - Per slot: BLANK while slot_cnt < BLANK_CYCLES, otherwise DRIVE.
  - slot_cnt counts 0..REFRESH_DIV-1 and then wraps. On wrap, scan_index increments modulo NUM_DIGITS.
  - BLANK: anode_out = all 1, seg_out = 8'hFF.
  - DRIVE: anode_out[scan_index] = 0 (others 1), seg_out = active[scan_index].
- Registered outputs:
  - seg_out, anode_out, frame_tick and wr_err are registered and lag internal state by 1 cycle.
  - scan_index is a direct register output.
  - frame_tick = registered copy_cycle.
- blank_all:
  - Forces the BLANK output values (one-cycle latency) while high.
  - Counters, writes and copies continue unaffected.
- Invariant: at most one anode_out bit is ever 0.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2; cycle 1 = first edge after reset drops):
- Reset release, no writes -> anode_out = 4'b1111 in cycles 1-2; 4'b1110 with seg_out = 8'hFF in cycles 3-8; 4'b1101 in cycles 11-16; frame_tick high only in cycle 32.
- Write idx 0 = 8'hC0 and idx 3 = 8'hF9 at cycles 1-2 -> seg_out stays 8'hFF through frame 1; from cycle 35, seg_out = 8'hC0 with anode_out = 4'b1110; from cycle 59, seg_out = 8'hF9 with anode_out = 4'b0111.
- wr_valid held high at cycle 31 (copy_cycle) -> wr_ready = 0 in cycle 31; write taken at cycle 32; data appears in frame 3, not frame 2.
- Write idx 2 = 8'hA4 while scanning digit 2 in frame 2 -> the displayed value changes only in the frame-3 digit-2 slot.
- blank_all high for cycles 35-40 -> anode_out = 4'b1111 and seg_out = 8'hFF in cycles 36-41; scan_index still advances to 1 at cycle 41.
- Reset asserted at cycle 20 for 1 cycle -> all outputs return to reset values, buffers = 8'hFF, scan restarts at digit 0 with the cycle-1 timing.
